// File: rtl/disp_pkg.sv
// Shared constants for the two-digit seven-segment display path.
package disp_pkg;

  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 2;

  localparam logic [DIG_W-1:0] COD_APAGADO = 4'd14;
  localparam logic [DIG_W-1:0] COD_TRACO   = 4'd15;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_TRACO = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF   = 7'h00;

  typedef enum logic {
    SLOT_UNI = 1'b0,
    SLOT_DEZ = 1'b1
  } slot_e;

endpackage

// File: rtl/bcd_7seg.sv
// Combinational decode of a display code to active-high segments.
import disp_pkg::*;

module bcd_7seg (
  input  logic [DIG_W-1:0] code_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    if (!blank_i) begin
      unique case (code_i)
        4'd0:      seg_c = SEG_0;
        4'd1:      seg_c = SEG_1;
        4'd2:      seg_c = SEG_2;
        4'd3:      seg_c = SEG_3;
        4'd4:      seg_c = SEG_4;
        4'd5:      seg_c = SEG_5;
        4'd6:      seg_c = SEG_6;
        4'd7:      seg_c = SEG_7;
        4'd8:      seg_c = SEG_8;
        4'd9:      seg_c = SEG_9;
        COD_TRACO: seg_c = SEG_TRACO;
        default:   seg_c = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/display_mux2.sv
// Two-digit multiplexed seven-segment driver with frame-aligned commit,
// leading-zero suppression and blinking.
import disp_pkg::*;

module display_mux2 #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 25,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIG_W-1:0] dezena,
  input  logic [DIG_W-1:0] unidade,
  input  logic             load,
  input  logic             blink,
  input  logic             supress_zero,
  output logic [SEG_W-1:0] segmentos,
  output logic [AN_W-1:0]  anodo
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [SEG_W-1:0] SEG_RST = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [AN_W-1:0]  AN_RST  = ACTIVE_LOW ? ~AN_W'(0) : AN_W'(0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_e            slot_q, slot_d;
  logic             fase_q, fase_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [DIG_W-1:0] sh_dez_q, sh_dez_d, sh_uni_q, sh_uni_d;
  logic [DIG_W-1:0] at_dez_q, at_dez_d, at_uni_q, at_uni_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [AN_W-1:0]  an_q, an_d;

  logic             wrap_c, frame_start_c, blank_c, visible_c;
  logic [DIG_W-1:0] digit_c;
  logic [SEG_W-1:0] seg_raw_c;
  logic [AN_W-1:0]  an_raw_c;

  bcd_7seg u_dec (
    .code_i  (digit_c),
    .blank_i (blank_c),
    .seg_c   (seg_raw_c)
  );

  always_comb begin
    wrap_c        = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_start_c = wrap_c && (slot_q == SLOT_DEZ);

    cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (wrap_c) slot_d = (slot_q == SLOT_UNI) ? SLOT_DEZ : SLOT_UNI;

    // A load on the commit cycle bypasses straight into the active pair
    sh_dez_d = load ? dezena  : sh_dez_q;
    sh_uni_d = load ? unidade : sh_uni_q;
    at_dez_d = frame_start_c ? sh_dez_d : at_dez_q;
    at_uni_d = frame_start_c ? sh_uni_d : at_uni_q;

    fase_d    = fase_q;
    blk_cnt_d = blk_cnt_q;
    if (!blink) begin
      fase_d    = 1'b1;
      blk_cnt_d = '0;
    end else if (frame_start_c) begin
      if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        fase_d    = ~fase_q;
        blk_cnt_d = '0;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end

    digit_c   = (slot_q == SLOT_DEZ) ? at_dez_q : at_uni_q;
    blank_c   = (slot_q == SLOT_DEZ) && supress_zero && (at_dez_q == DIG_W'(0));
    // Dead time at cnt=0; blink level acts immediately, not at frame edges
    visible_c = (cnt_q != '0) && (fase_q || !blink);
    an_raw_c  = '0;
    if (visible_c) an_raw_c = (slot_q == SLOT_DEZ) ? 2'b10 : 2'b01;

    seg_d = ACTIVE_LOW ? ~seg_raw_c : seg_raw_c;
    an_d  = ACTIVE_LOW ? ~an_raw_c  : an_raw_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      slot_q    <= SLOT_UNI;
      fase_q    <= 1'b1;
      blk_cnt_q <= '0;
      sh_dez_q  <= COD_APAGADO;
      sh_uni_q  <= COD_APAGADO;
      at_dez_q  <= COD_APAGADO;
      at_uni_q  <= COD_APAGADO;
      seg_q     <= SEG_RST;
      an_q      <= AN_RST;
    end else begin
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      fase_q    <= fase_d;
      blk_cnt_q <= blk_cnt_d;
      sh_dez_q  <= sh_dez_d;
      sh_uni_q  <= sh_uni_d;
      at_dez_q  <= at_dez_d;
      at_uni_q  <= at_uni_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign segmentos = seg_q;
  assign anodo     = an_q;

endmodule

// File: tb/tb_display_mux2.sv
// Bench for display_mux2: cycle-level reference model, vector table and corner sequences.
module tb_display_mux2;

  localparam int R = 4;
  localparam int F = 2 * R;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0, blink = 1'b0, sz = 1'b0;
  logic [3:0] dez = 4'd0, uni = 4'd0;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;

  always #5 clock = ~clock;

  display_mux2 #(.REFRESH_DIV(R), .BLINK_DIV(2), .ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .dezena(dez), .unidade(uni), .load(load),
    .blink(blink), .supress_zero(sz), .segmentos(seg_a), .anodo(an_a));

  display_mux2 #(.REFRESH_DIV(R), .BLINK_DIV(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clock(clock), .reset(reset), .dezena(dez), .unidade(uni), .load(load),
    .blink(blink), .supress_zero(sz), .segmentos(seg_b), .anodo(an_b));

  int n_chk = 0;
  int n_err = 0;

  // Model state: cycles since reset, shadow/active digits, blinking frames seen
  int         m_t, m_bf;
  logic [3:0] m_shd, m_shu, m_atd, m_atu;
  logic [6:0] e_seg;
  logic [1:0] e_an_a, e_an_b;

  typedef struct {
    logic [3:0] d;
    logic [3:0] u;
    logic       s;
    logic [6:0] tens;
    logic [6:0] units;
  } vec_t;
  vec_t tbl[6];

  task automatic check7(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    logic [6:0] pat[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (c < 4'd10) return pat[c];
    if (c == 4'd15) return 7'h40;
    return 7'h00;
  endfunction

  function automatic logic [1:0] on_mask(input int cm, input int sl, input int bd);
    if (cm == 0) return 2'b00;
    if (blink && ((m_bf / bd) % 2) != 0) return 2'b00;
    return (sl == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_step();
    int cm, sl;
    logic [3:0] d;
    if (reset) begin
      e_seg = 7'h7F; e_an_a = 2'b11; e_an_b = 2'b11;
      m_t = 0; m_bf = 0;
      m_shd = 4'd14; m_shu = 4'd14; m_atd = 4'd14; m_atu = 4'd14;
    end else begin
      cm = m_t % R;
      sl = (m_t / R) % 2;
      d  = (sl == 1) ? m_atd : m_atu;
      e_seg  = (sl == 1 && sz && m_atd == 4'd0) ? 7'h7F : ~ref_seg(d);
      e_an_a = ~on_mask(cm, sl, 2);
      e_an_b = ~on_mask(cm, sl, 1);
      m_t++;
      if (load) begin m_shd = dez; m_shu = uni; end
      if (m_t % F == 0) begin
        m_atd = m_shd; m_atu = m_shu;
        if (blink) m_bf++;
      end
      if (!blink) m_bf = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check7("model_seg_a", seg_a, e_seg);
    check7("model_seg_b", seg_b, e_seg);
    check7("model_an_a", 7'(an_a), 7'(e_an_a));
    check7("model_an_b", 7'(an_b), 7'(e_an_b));
  endtask

  // Advance until the model time sits at the given frame phase
  task automatic run_to(input int ph);
    for (int k = 0; k < F; k++) begin
      tick();
      if (m_t % F == ph) break;
    end
  endtask

  task automatic do_load(input logic [3:0] d, input logic [3:0] u);
    dez = d; uni = u; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    tbl[0] = '{d: 4'd4,  u: 4'd2,  s: 1'b0, tens: 7'h19, units: 7'h24};
    tbl[1] = '{d: 4'd15, u: 4'd14, s: 1'b0, tens: 7'h3F, units: 7'h7F};
    tbl[2] = '{d: 4'd0,  u: 4'd5,  s: 1'b1, tens: 7'h7F, units: 7'h12};
    tbl[3] = '{d: 4'd0,  u: 4'd5,  s: 1'b0, tens: 7'h40, units: 7'h12};
    tbl[4] = '{d: 4'd9,  u: 4'd8,  s: 1'b0, tens: 7'h10, units: 7'h00};
    tbl[5] = '{d: 4'd11, u: 4'd7,  s: 1'b0, tens: 7'h7F, units: 7'h78};

    // Reset held three cycles
    reset = 1'b1;
    repeat (3) tick();
    check7("reset_seg", seg_a, 7'h7F);
    check7("reset_an", 7'(an_a), 7'(2'b11));
    reset = 1'b0;
    run_to(1);
    check7("first_dead_an", 7'(an_a), 7'(2'b11));
    run_to(2);
    check7("first_units_blank", seg_a, 7'h7F);
    check7("first_units_an", 7'(an_a), 7'(2'b10));

    for (int i = 0; i < 6; i++) begin
      run_to(3);
      sz = tbl[i].s;
      do_load(tbl[i].d, tbl[i].u);
      run_to(1);
      check7("tbl_dead_an", 7'(an_a), 7'(2'b11));
      run_to(2);
      check7("tbl_units_seg", seg_a, tbl[i].units);
      check7("tbl_units_an", 7'(an_a), 7'(2'b10));
      run_to(R + 2);
      check7("tbl_tens_seg", seg_a, tbl[i].tens);
      check7("tbl_tens_an", 7'(an_a), 7'(2'b01));
    end

    // Mid-frame load held off until the frame start
    run_to(3);
    do_load(4'd4, 4'd2);
    run_to(R + 2);
    check7("no_early_commit", seg_a, 7'h7F);
    run_to(2);
    check7("commit_units", seg_a, 7'h24);

    // Two loads in one frame: only the last is shown
    run_to(2);
    do_load(4'd14, 4'd3);
    run_to(5);
    do_load(4'd14, 4'd7);
    run_to(2);
    check7("last_load_wins", seg_a, 7'h78);

    // Load exactly on the commit cycle appears in that frame
    run_to(F - 1);
    do_load(4'd14, 4'd1);
    run_to(2);
    check7("load_on_commit", seg_a, 7'h79);

    // Blink: dut_b toggles every frame, dut every two frames
    run_to(0);
    blink = 1'b1;
    run_to(2);
    check7("blink_f0_b", 7'(an_b), 7'(2'b10));
    run_to(2);
    check7("blink_f1_b_dark", 7'(an_b), 7'(2'b11));
    check7("blink_f1_a_vis", 7'(an_a), 7'(2'b10));
    run_to(2);
    check7("blink_f2_b_vis", 7'(an_b), 7'(2'b10));
    check7("blink_f2_a_dark", 7'(an_a), 7'(2'b11));
    run_to(2);
    check7("blink_f3_b_dark", 7'(an_b), 7'(2'b11));
    blink = 1'b0;
    tick();
    check7("blink_drop_b", 7'(an_b), 7'(2'b10));
    check7("blink_drop_a", 7'(an_a), 7'(2'b10));

    // Reset mid-blink with a pending shadow value
    blink = 1'b1;
    run_to(3);
    do_load(4'd5, 4'd5);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    run_to(2);
    check7("reset_discard_seg", seg_a, 7'h7F);
    check7("reset_blink_vis", 7'(an_b), 7'(2'b10));
    blink = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      load  = ($urandom_range(0, 4) == 0);
      dez   = 4'($urandom);
      uni   = 4'($urandom);
      if ($urandom_range(0, 39) == 0) blink = ~blink;
      if ($urandom_range(0, 29) == 0) sz = ~sz;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
